// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory arbiter slice.
// Widths, byte-mask encodings and port indices.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 30;
  localparam int DMEM_DATA_W = 32;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  localparam int PORT_CPU = 0;
  localparam int PORT_DBG = 1;

  localparam int WCNT_W = 4;

endpackage

// File: rtl/dmem_arb_prio.sv
// Fixed-priority grant with anti-starvation counter.
// In: clk, rst, p0_req, p1_req. Out: gnt[1:0], wcnt.
module dmem_arb_prio
  import dmem_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p1_req,
  output logic [1:0]        gnt,
  output logic [WCNT_W-1:0] wcnt
);

  logic starve;
  logic g0;
  logic g1;

  assign starve = (wcnt >= WCNT_W'(MAX_WAIT));

  always_comb begin
    g1 = p1_req & (~p0_req | starve) & ~rst;
    g0 = p0_req & ~g1 & ~rst;
  end

  assign gnt[PORT_CPU] = g0;
  assign gnt[PORT_DBG] = g1;

  // Counts consecutive denied cycles; any gap
  // in port 1 requests restarts the wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt <= '0;
    end else if (p1_req & ~g1) begin
      if (wcnt != '1)
        wcnt <= wcnt + 1'b1;
    end else begin
      wcnt <= '0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of single-port data memory.
// p0 = CPU MEM stage, p1 = debug/DMA; mem_* to the RAM.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [3:0]        p0_wmask,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [3:0]        p1_wmask,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_we,
  output logic [3:0]        mem_wmask,
  output logic [ADDR_W-1:0] mem_A,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  logic [1:0]        gnt;
  logic [WCNT_W-1:0] wcnt;
  logic              p0_rd;
  logic              p1_rd;

  dmem_arb_prio #(
    .MAX_WAIT(MAX_WAIT)
  ) u_prio (
    .clk   (clk),
    .rst   (rst),
    .p0_req(p0_req),
    .p1_req(p1_req),
    .gnt   (gnt),
    .wcnt  (wcnt)
  );

  assign p0_gnt = gnt[PORT_CPU];
  assign p1_gnt = gnt[PORT_DBG];

  always_comb begin
    mem_we    = 1'b0;
    mem_wmask = '0;
    mem_A     = '0;
    mem_wd    = '0;
    unique case (1'b1)
      p0_gnt: begin
        mem_we    = p0_we;
        mem_wmask = p0_wmask;
        mem_A     = p0_addr;
        mem_wd    = p0_wdata;
      end
      p1_gnt: begin
        mem_we    = p1_we;
        mem_wmask = p1_wmask;
        mem_A     = p1_addr;
        mem_wd    = p1_wdata;
      end
      default: ;
    endcase
  end

  assign p0_rd = p0_gnt & ~p0_we;
  assign p1_rd = p1_gnt & ~p1_we;

  // rdata is sticky: only a new read grant
  // to that port replaces it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      p0_rvalid <= p0_rd;
      p1_rvalid <= p1_rd;
      if (p0_rd)
        p0_rdata <= mem_rd;
      if (p1_rd)
        p1_rdata <= mem_rd;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a
// small negedge-write memory model.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        p0_req;
  logic        p0_we;
  logic [3:0]  p0_wmask;
  logic [29:0] p0_addr;
  logic [31:0] p0_wdata;
  logic        p0_gnt;
  logic        p0_rvalid;
  logic [31:0] p0_rdata;
  logic        p1_req;
  logic        p1_we;
  logic [3:0]  p1_wmask;
  logic [29:0] p1_addr;
  logic [31:0] p1_wdata;
  logic        p1_gnt;
  logic        p1_rvalid;
  logic [31:0] p1_rdata;
  logic        mem_we;
  logic [3:0]  mem_wmask;
  logic [29:0] mem_A;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem [0:63];
  int n_chk;
  int n_fail;

  dmem_arbiter #(
    .ADDR_W  (30),
    .DATA_W  (32),
    .MAX_WAIT(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .p0_req   (p0_req),
    .p0_we    (p0_we),
    .p0_wmask (p0_wmask),
    .p0_addr  (p0_addr),
    .p0_wdata (p0_wdata),
    .p0_gnt   (p0_gnt),
    .p0_rvalid(p0_rvalid),
    .p0_rdata (p0_rdata),
    .p1_req   (p1_req),
    .p1_we    (p1_we),
    .p1_wmask (p1_wmask),
    .p1_addr  (p1_addr),
    .p1_wdata (p1_wdata),
    .p1_gnt   (p1_gnt),
    .p1_rvalid(p1_rvalid),
    .p1_rdata (p1_rdata),
    .mem_we   (mem_we),
    .mem_wmask(mem_wmask),
    .mem_A    (mem_A),
    .mem_wd   (mem_wd),
    .mem_rd   (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd = mem[mem_A[5:0]];

  // Memory reloads its image while in reset.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++)
        mem[i] = 32'h0;
      mem[25] = 32'h84755779;
      mem[1]  = 32'h08000000;
      mem[6]  = 32'h00000066;
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b])
          mem[mem_A[5:0]][8*b +: 8] =
            mem_wd[8*b +: 8];
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p0_req = 0; p0_we = 0; p0_wmask = 0;
    p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_wmask = 0;
    p1_addr = 0; p1_wdata = 0;
  endtask

  task automatic rd0(input logic [29:0] a);
    p0_req = 1; p0_we = 0; p0_addr = a;
  endtask

  task automatic rd1(input logic [29:0] a);
    p1_req = 1; p1_we = 0; p1_addr = a;
  endtask

  task automatic wr0(input logic [29:0] a,
                     input logic [3:0] m,
                     input logic [31:0] d);
    p0_req = 1; p0_we = 1; p0_addr = a;
    p0_wmask = m; p0_wdata = d;
  endtask

  task automatic wr1(input logic [29:0] a,
                     input logic [3:0] m,
                     input logic [31:0] d);
    p1_req = 1; p1_we = 1; p1_addr = a;
    p1_wmask = m; p1_wdata = d;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1;
    idle();
    wr0(25, 4'hF, 32'h12345678);
    rd1(5);
    #2;
    check("rst_p0_gnt", 32'(p0_gnt), 0);
    check("rst_p1_gnt", 32'(p1_gnt), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_A", 32'(mem_A), 0);
    check("rst_rvalid", 32'(p0_rvalid), 0);
    nxt();
    nxt();
    rst = 0;
    idle();
    #1;
    check("rel_p0_rdata", p0_rdata, 0);
    check("rel_p1_rdata", p1_rdata, 0);
    check("rel_wcnt", 32'(dut.u_prio.wcnt), 0);

    // single read
    nxt(); rd0(25); #1;
    check("rd_gnt", 32'(p0_gnt), 1);
    check("rd_p1_gnt", 32'(p1_gnt), 0);
    check("rd_mem_A", 32'(mem_A), 25);
    check("rd_mem_we", 32'(mem_we), 0);
    nxt(); idle(); #1;
    check("rd_rvalid", 32'(p0_rvalid), 1);
    check("rd_rdata", p0_rdata, 32'h84755779);
    check("rd_idle_A", 32'(mem_A), 0);
    nxt(); #1;
    check("rd_rv_low", 32'(p0_rvalid), 0);
    check("rd_hold", p0_rdata, 32'h84755779);

    // masked write then read on port 1
    nxt(); wr1(5, 4'b0010, 32'hAABBCCDD); #1;
    check("mw_gnt", 32'(p1_gnt), 1);
    check("mw_we", 32'(mem_we), 1);
    check("mw_mask", 32'(mem_wmask), 2);
    check("mw_A", 32'(mem_A), 5);
    check("mw_wd", mem_wd, 32'hAABBCCDD);
    nxt(); idle(); rd1(5); #1;
    check("mw_rd_gnt", 32'(p1_gnt), 1);
    check("mw_no_rv", 32'(p1_rvalid), 0);
    nxt(); idle(); #1;
    check("mw_rv", 32'(p1_rvalid), 1);
    check("mw_rdata", p1_rdata, 32'h0000CC00);

    // zero-mask write is granted, stores nothing
    nxt(); wr0(25, 4'h0, 32'hFFFFFFFF); #1;
    check("zm_gnt", 32'(p0_gnt), 1);
    check("zm_mask", 32'(mem_wmask), 0);
    nxt(); idle(); rd0(25); #1;
    check("zm_rv_none", 32'(p0_rvalid), 0);
    nxt(); idle(); #1;
    check("zm_rdata", p0_rdata, 32'h84755779);

    // contention: 4 x p0 then 1 x p1
    nxt(); rd0(25); rd1(5);
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("ct_p0_%0d", i),
            32'(p0_gnt), (i % 5 != 4) ? 1 : 0);
      check($sformatf("ct_p1_%0d", i),
            32'(p1_gnt), (i % 5 == 4) ? 1 : 0);
      if (i == 4)
        check("ct_mux_A", 32'(mem_A), 5);
      nxt();
    end
    idle(); #1;
    check("ct_p1_rv", 32'(p1_rvalid), 1);
    check("ct_p0_rv", 32'(p0_rvalid), 0);

    // starvation counter cleared by a gap
    nxt(); rd0(25); rd1(5); #1;
    check("sc_d0", 32'(p1_gnt), 0);
    nxt(); #1;
    check("sc_d1", 32'(p1_gnt), 0);
    nxt(); p1_req = 0; #1;
    check("sc_gap_p0", 32'(p0_gnt), 1);
    nxt(); p1_req = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("sc_p1_%0d", i),
            32'(p1_gnt), (i == 4) ? 1 : 0);
      nxt();
    end
    idle();

    // back-to-back reads on port 0
    nxt(); rd0(0); #1;
    check("bb_g0", 32'(p0_gnt), 1);
    nxt(); rd0(1); #1;
    check("bb_g1", 32'(p0_gnt), 1);
    check("bb_rv0", 32'(p0_rvalid), 1);
    check("bb_rd0", p0_rdata, 32'h00000000);
    nxt(); idle(); #1;
    check("bb_rv1", 32'(p0_rvalid), 1);
    check("bb_rd1", p0_rdata, 32'h08000000);
    nxt(); #1;
    check("bb_rv_end", 32'(p0_rvalid), 0);

    // asynchronous reset mid-operation
    nxt(); rd0(25); rd1(5); #1;
    check("ar_g", 32'(p0_gnt), 1);
    nxt(); wr0(6, 4'hF, 32'hDEADBEEF); #1;
    check("ar_rv", 32'(p0_rvalid), 1);
    check("ar_we", 32'(mem_we), 1);
    #1 rst = 1;
    #1;
    check("ar_p0_gnt", 32'(p0_gnt), 0);
    check("ar_p1_gnt", 32'(p1_gnt), 0);
    check("ar_rv0", 32'(p0_rvalid), 0);
    check("ar_mem_we", 32'(mem_we), 0);
    check("ar_rdata", p0_rdata, 0);
    idle();
    nxt();
    rst = 0;
    nxt(); #1;
    check("ar_wcnt", 32'(dut.u_prio.wcnt), 0);
    check("ar_no_rv", 32'(p0_rvalid), 0);
    nxt(); rd0(6); #1;
    nxt(); idle(); #1;
    check("ar_mem6", p0_rdata, 32'h00000066);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
